conv_tile_loader: RTL and testbench

Front-end feeder for the 3x3 convolution array: accepts a raster-order stream of 2-bit pixels over a valid/ready handshake, assembles 25 pixels into a 5x5 window tile, and presents the tile plus a coherent 3x3 filter word to the convolution core. It double-buffers tiles so pixel intake overlaps presentation. It also latches filter updates so that a new filter takes effect only at a tile boundary.

---
 rtl/conv_tile_loader.sv | 147 ++++++++++++++
 tb/tb_conv_tile_loader.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_tile_loader.sv
//============================================================================
// Module      : conv_tile_loader
// Description : Assembles a raster stream of pixels into WIN x WIN tiles,
//               double-buffers them (working buffer + output stage) and
//               presents each tile together with a 3x3 filter word that only
//               changes at tile boundaries.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module conv_tile_loader #(
    parameter int PIX_W = 2,
    parameter int WIN   = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PIX_W-1:0]         px_data,
    input  logic                     px_valid,
    output logic                     px_ready,
    input  logic                     tile_abort,
    input  logic                     flt_we,
    input  logic [9*PIX_W-1:0]       flt_wdata,
    output logic [WIN*WIN*PIX_W-1:0] tile_out,
    output logic [9*PIX_W-1:0]       filter_out,
    output logic                     tile_valid,
    input  logic                     tile_ready,
    output logic [15:0]              tile_cnt
);

    localparam int N_PIX  = WIN * WIN;
    localparam int TILE_W = N_PIX * PIX_W;
    localparam int FLT_W  = 9 * PIX_W;
    localparam int CNT_W  = $clog2(N_PIX);
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(N_PIX - 1);

    typedef enum logic [0:0] {
        FLT_NO_PEND = 1'b0,
        FLT_PEND    = 1'b1
    } flt_state_t;

    // Working buffer
    logic [TILE_W-1:0] r_wbuf;
    logic [CNT_W-1:0]  r_wcnt;
    logic              r_wfull;

    // Output stage
    logic [TILE_W-1:0] r_tile_out;
    logic [FLT_W-1:0]  r_filter_out;
    logic              r_tile_valid;
    logic [15:0]       r_tile_cnt;

    // Filter shadow
    logic [FLT_W-1:0]  r_shadow;
    flt_state_t        r_flt_state;

    logic              w_px_acc;
    logic              w_tile_done;
    logic              w_stage_free;
    logic              w_xfer;
    logic [TILE_W-1:0] w_wbuf_next;

    // Handshake and transfer decisions. The final pixel may go straight to
    // the output stage in the cycle it arrives, so a free stage never makes
    // px_ready drop and tile_valid follows pixel 24 by one cycle.
    always_comb begin
        w_px_acc     = px_valid && !r_wfull && !tile_abort;
        w_tile_done  = w_px_acc && (r_wcnt == LAST_PIX);
        w_stage_free = !r_tile_valid || tile_ready;
        w_xfer       = (r_wfull || w_tile_done) && w_stage_free && !tile_abort;
        w_wbuf_next  = r_wbuf;
        if (w_px_acc) begin
            w_wbuf_next[int'(r_wcnt)*PIX_W +: PIX_W] = px_data;
        end
    end

    assign px_ready   = !r_wfull;
    assign tile_out   = r_tile_out;
    assign filter_out = r_filter_out;
    assign tile_valid = r_tile_valid;
    assign tile_cnt   = r_tile_cnt;

    // Working buffer: pixel slot writes, fill count and full flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wbuf  <= '0;
            r_wcnt  <= '0;
            r_wfull <= 1'b0;
        end else if (tile_abort) begin
            r_wcnt  <= '0;
            r_wfull <= 1'b0;
        end else begin
            if (w_px_acc) begin
                r_wbuf <= w_wbuf_next;
                r_wcnt <= w_tile_done ? '0 : r_wcnt + 1'b1;
            end
            if (w_xfer) begin
                r_wfull <= 1'b0;
            end else if (w_tile_done) begin
                r_wfull <= 1'b1;
            end
        end
    end

    // Output stage: load on transfer, drop valid on a consume with no refill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tile_out   <= '0;
            r_tile_valid <= 1'b0;
            r_tile_cnt   <= '0;
        end else begin
            if (w_xfer) begin
                r_tile_out   <= w_wbuf_next;
                r_tile_valid <= 1'b1;
            end else if (tile_ready) begin
                r_tile_valid <= 1'b0;
            end
            if (r_tile_valid && tile_ready) begin
                r_tile_cnt <= r_tile_cnt + 16'd1;
            end
        end
    end

    // Filter shadow and pending state; a pending filter is applied only with
    // a transfer, and a write in that same cycle stays pending for the next
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow     <= '0;
            r_filter_out <= '0;
            r_flt_state  <= FLT_NO_PEND;
        end else begin
            if (w_xfer && (r_flt_state == FLT_PEND)) begin
                r_filter_out <= r_shadow;
            end
            if (flt_we) begin
                r_shadow <= flt_wdata;
            end
            case (r_flt_state)
                FLT_NO_PEND: if (flt_we) r_flt_state <= FLT_PEND;
                FLT_PEND:    if (w_xfer && !flt_we) r_flt_state <= FLT_NO_PEND;
                default:     r_flt_state <= FLT_NO_PEND;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_conv_tile_loader.sv
//============================================================================
// Module      : tb_conv_tile_loader
// Description : Self-checking bench for conv_tile_loader. A reference model
//               rebuilds each tile from accepted pixels and queues it with
//               the filter it must carry; consumed tiles are popped and
//               compared.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_conv_tile_loader;

    localparam int PIX_W  = 2;
    localparam int WIN    = 5;
    localparam int TILE_W = WIN * WIN * PIX_W;
    localparam int FLT_W  = 9 * PIX_W;

    logic              clk;
    logic              rst_n;
    logic [PIX_W-1:0]  px_data;
    logic              px_valid;
    logic              px_ready;
    logic              tile_abort;
    logic              flt_we;
    logic [FLT_W-1:0]  flt_wdata;
    logic [TILE_W-1:0] tile_out;
    logic [FLT_W-1:0]  filter_out;
    logic              tile_valid;
    logic              tile_ready;
    logic [15:0]       tile_cnt;

    conv_tile_loader #(.PIX_W(PIX_W), .WIN(WIN)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .px_data    (px_data),
        .px_valid   (px_valid),
        .px_ready   (px_ready),
        .tile_abort (tile_abort),
        .flt_we     (flt_we),
        .flt_wdata  (flt_wdata),
        .tile_out   (tile_out),
        .filter_out (filter_out),
        .tile_valid (tile_valid),
        .tile_ready (tile_ready),
        .tile_cnt   (tile_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    logic [TILE_W-1:0] m_tile;
    int                m_cnt;
    logic [FLT_W-1:0]  exp_filt;
    logic [TILE_W-1:0] q_tile[$];
    logic [FLT_W-1:0]  q_filt[$];
    int                n_push;
    int                n_pop;
    bit                last_acc;
    bit                was_stall;
    logic [TILE_W-1:0] prev_tile;
    logic [FLT_W-1:0]  prev_filt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_tile    = '0;
        m_cnt     = 0;
        q_tile.delete();
        q_filt.delete();
        n_push    = 0;
        n_pop     = 0;
        was_stall = 1'b0;
    endtask

    // One clock: observe handshakes mid-cycle, update model and scoreboard,
    // then return just after the next rising edge.
    task automatic step();
        logic [TILE_W-1:0] et;
        logic [FLT_W-1:0]  ef;
        @(negedge clk);
        last_acc = px_valid && px_ready && !tile_abort;
        if (tile_abort) begin
            m_cnt = 0;
        end else if (last_acc) begin
            m_tile[m_cnt*PIX_W +: PIX_W] = px_data;
            m_cnt++;
            if (m_cnt == WIN * WIN) begin
                q_tile.push_back(m_tile);
                q_filt.push_back(exp_filt);
                n_push++;
                m_cnt = 0;
            end
        end
        if (was_stall) begin
            chk("stall_tile_stable", 64'(tile_out), 64'(prev_tile));
            chk("stall_filt_stable", 64'(filter_out), 64'(prev_filt));
        end
        if (tile_valid && tile_ready) begin
            if (q_tile.size() == 0) begin
                chk("sb_unexpected_tile", 64'(1), 64'(0));
            end else begin
                et = q_tile.pop_front();
                ef = q_filt.pop_front();
                chk("sb_tile", 64'(tile_out), 64'(et));
                chk("sb_filter", 64'(filter_out), 64'(ef));
                n_pop++;
            end
        end
        was_stall = tile_valid && !tile_ready;
        prev_tile = tile_out;
        prev_filt = filter_out;
        @(posedge clk);
        #1;
    endtask

    // Offer n pixels; ramp selects p%4 data, otherwise the constant val
    task automatic stream(input int n, input bit ramp, input logic [1:0] val);
        int guard;
        for (int i = 0; i < n; i++) begin
            guard    = 0;
            px_valid = 1'b1;
            px_data  = ramp ? 2'(i % 4) : val;
            do begin
                step();
                guard++;
            end while (!last_acc && guard < 200);
            if (!last_acc) begin
                chk("px_accept_timeout", 64'(0), 64'(1));
                break;
            end
        end
        px_valid = 1'b0;
    endtask

    task automatic flt_write(input logic [FLT_W-1:0] v);
        flt_we    = 1'b1;
        flt_wdata = v;
        step();
        flt_we    = 1'b0;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        px_valid   = 1'b0;
        px_data    = '0;
        tile_abort = 1'b0;
        flt_we     = 1'b0;
        flt_wdata  = '0;
        tile_ready = 1'b0;
        model_clear();
        exp_filt   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    localparam logic [TILE_W-1:0] ALL1 = {25{2'b01}};
    localparam logic [TILE_W-1:0] ALL2 = {25{2'b10}};
    localparam logic [TILE_W-1:0] ALL3 = {25{2'b11}};

    initial begin
        int cyc;

        do_reset();
        // Reset values
        chk("rst_tile_valid", 64'(tile_valid), 64'(0));
        chk("rst_px_ready", 64'(px_ready), 64'(1));
        chk("rst_tile_out", 64'(tile_out), 64'(0));
        chk("rst_filter_out", 64'(filter_out), 64'(0));
        chk("rst_tile_cnt", 64'(tile_cnt), 64'(0));

        // Ramp tile with consumer always ready
        tile_ready = 1'b1;
        stream(25, 1'b1, 2'd0);
        chk("t1_valid_after_p24", 64'(tile_valid), 64'(1));
        chk("t1_pix0", 64'(tile_out[1:0]), 64'(0));
        chk("t1_pix24", 64'(tile_out[49:48]), 64'(0));
        chk("t1_pix3", 64'(tile_out[7:6]), 64'(3));
        step();
        chk("t1_valid_one_cycle", 64'(tile_valid), 64'(0));
        chk("t1_tile_cnt", 64'(tile_cnt), 64'(1));

        // Backpressure: two tiles in flight
        tile_ready = 1'b0;
        stream(25, 1'b0, 2'd1);
        stream(25, 1'b0, 2'd2);
        chk("t2_px_ready_low", 64'(px_ready), 64'(0));
        chk("t2_hold_all1", 64'(tile_out), 64'(ALL1));
        step();
        tile_ready = 1'b1;
        step();
        tile_ready = 1'b0;
        chk("t2_next_all2", 64'(tile_out), 64'(ALL2));
        chk("t2_valid_kept", 64'(tile_valid), 64'(1));
        chk("t2_px_ready_back", 64'(px_ready), 64'(1));
        tile_ready = 1'b1;
        step();

        // Filter applied at the next transfer, not mid-presentation
        tile_ready = 1'b0;
        stream(25, 1'b0, 2'd0);
        flt_write(18'h2AAAA);
        chk("t3_filt_unchanged", 64'(filter_out), 64'(0));
        exp_filt = 18'h2AAAA;
        stream(25, 1'b0, 2'd3);
        step();
        chk("t3_filt_still_old", 64'(filter_out), 64'(0));
        tile_ready = 1'b1;
        step();
        chk("t3_filt_new", 64'(filter_out), 64'(18'h2AAAA));
        step();

        // Filter write coinciding with a transfer
        tile_ready = 1'b0;
        stream(25, 1'b1, 2'd0);
        flt_write(18'h11111);
        exp_filt = 18'h11111;
        stream(25, 1'b0, 2'd2);
        tile_ready = 1'b1;
        flt_write(18'h15555);
        chk("t3c_pre_write_shadow", 64'(filter_out), 64'(18'h11111));
        exp_filt = 18'h15555;
        step();
        stream(25, 1'b0, 2'd1);
        step();
        chk("t3c_next_tile_filter", 64'(filter_out), 64'(18'h15555));

        // Abort discards a partial tile and the pixel offered with it
        tile_ready = 1'b1;
        stream(10, 1'b0, 2'd1);
        px_valid   = 1'b1;
        px_data    = 2'd2;
        tile_abort = 1'b1;
        step();
        tile_abort = 1'b0;
        px_valid   = 1'b0;
        stream(25, 1'b0, 2'd3);
        chk("t4_abort_all3", 64'(tile_out), 64'(ALL3));
        step();

        // Random traffic, 1000 tiles
        do_reset();
        cyc = 0;
        while (n_pop < 1000 && cyc < 60000) begin
            px_valid   = (n_push < 1000) && ($urandom_range(0, 7) != 0);
            px_data    = 2'($urandom);
            tile_ready = ($urandom_range(0, 3) != 0);
            step();
            cyc++;
        end
        px_valid = 1'b0;
        chk("rnd_tiles_consumed", 64'(n_pop), 64'(1000));
        chk("rnd_tile_cnt", 64'(tile_cnt), 64'(1000));
        chk("rnd_queue_empty", 64'(q_tile.size()), 64'(0));

        // Asynchronous reset mid-tile while a tile is presented
        tile_ready = 1'b0;
        flt_write(18'h2AAAA);
        exp_filt = 18'h2AAAA;
        stream(25, 1'b0, 2'd2);
        stream(12, 1'b1, 2'd0);
        px_valid = 1'b1;
        px_data  = 2'd3;
        rst_n    = 1'b0;
        #1;
        chk("t6_rst_tile_valid", 64'(tile_valid), 64'(0));
        chk("t6_rst_tile_out", 64'(tile_out), 64'(0));
        chk("t6_rst_filter_out", 64'(filter_out), 64'(0));
        chk("t6_rst_tile_cnt", 64'(tile_cnt), 64'(0));
        chk("t6_rst_px_ready", 64'(px_ready), 64'(1));
        px_valid = 1'b0;
        model_clear();
        exp_filt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tile_ready = 1'b1;
        stream(25, 1'b1, 2'd0);
        step();
        chk("t6_reassembled", 64'(n_pop), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule

`default_nettype wire
